// File: rtl/qspi_scope_host.sv
// qspi_scope_host
// ---------------------------------------------------------------------------
// QSPI initiator that pulls a capture from the scope's QSPI slave port.
// A transfer is NSAMPLES write/read frame pairs. Each write frame carries one
// configuration byte: mode, speed, trigger and trigger_type for pairs 0..3,
// and 0x00 after that. Each read frame returns one sample byte, which is
// presented on an addressed byte strobe.
//
// Ports
//   clk               system clock
//   resetn            asynchronous active-low reset
//   start             one-cycle pulse, begins a transfer when idle
//   auto_en           lets a falling edge on req_n begin a transfer
//   req_n             asynchronous slave request line (active low)
//   cfg_mode          configuration byte sent in pair 0
//   cfg_speed         configuration byte sent in pair 1
//   cfg_trigger       configuration byte sent in pair 2
//   cfg_trigger_type  2-bit value sent zero-extended in pair 3
//   busy              high from transfer start until done
//   done              one-cycle pulse at the end of a transfer
//   sample_valid      one-cycle strobe per received byte
//   sample_addr       read-frame index of the received byte
//   sample_data       received byte
//   QCK / QSS / QD    QSPI clock (idles low), select (active low), data
// ---------------------------------------------------------------------------
module qspi_scope_host #(
  parameter int CLK_DIV  = 4,
  parameter int SS_GAP   = 16,
  parameter int NSAMPLES = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        auto_en,
  input  logic        req_n,
  input  logic [7:0]  cfg_mode,
  input  logic [7:0]  cfg_speed,
  input  logic [7:0]  cfg_trigger,
  input  logic [1:0]  cfg_trigger_type,
  output logic        busy,
  output logic        done,
  output logic        sample_valid,
  output logic [11:0] sample_addr,
  output logic [7:0]  sample_data,
  output logic        QCK,
  output logic        QSS,
  inout  wire  [3:0]  QD
);

  localparam int CW = 16;

  // Counter values at which the SHIFT-phase events happen. The counter runs
  // 0..4*CLK_DIV-1 through the two QCK pulses; each event is applied on the
  // clock edge that ends the listed count.
  localparam logic [CW-1:0] CD_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] P0_RISE    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] P0_FALL    = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] P1_RISE    = CW'(3 * CLK_DIV - 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(4 * CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(SS_GAP - 1);
  localparam logic [11:0]   LAST_P     = 12'(NSAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [11:0]   p_r;
  logic          rd_frame_r;
  logic          last_r;
  logic [7:0]    mode_r;
  logic [7:0]    speed_r;
  logic [7:0]    trig_r;
  logic [1:0]    trig_type_r;
  logic [3:0]    nib0_r;
  logic [7:0]    rx_r;
  logic          qd_oe_r;
  logic [3:0]    qd_out_r;

  logic          req_meta_r;
  logic          req_sync_r;
  logic          req_prev_r;
  logic          req_fall_r;

  logic          launch_s;
  logic [7:0]    wr_byte_s;

  // Payload of the write frame belonging to pair p.
  function automatic logic [7:0] wr_byte(
    input logic [11:0] p,
    input logic [7:0]  m,
    input logic [7:0]  s,
    input logic [7:0]  t,
    input logic [1:0]  tt
  );
    logic [7:0] b;
    case (p)
      12'd0:   b = m;
      12'd1:   b = s;
      12'd2:   b = t;
      12'd3:   b = {6'b000000, tt};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // The master only drives QD during write-frame select time.
  assign QD = qd_oe_r ? qd_out_r : 4'bzzzz;

  assign wr_byte_s = wr_byte(p_r, mode_r, speed_r, trig_r, trig_type_r);

  // Launch request: a start pulse, or a synchronised req_n falling edge when
  // auto mode is on. Both in the same cycle still launch a single transfer.
  always_comb begin
    if (start || (auto_en && req_fall_r)) begin
      launch_s = 1'b1;
    end else begin
      launch_s = 1'b0;
    end
  end

  // Two-flop synchroniser on req_n, then a registered falling-edge detector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_meta_r <= 1'b1;
      req_sync_r <= 1'b1;
      req_prev_r <= 1'b1;
      req_fall_r <= 1'b0;
    end else begin
      req_meta_r <= req_n;
      req_sync_r <= req_meta_r;
      req_prev_r <= req_sync_r;
      req_fall_r <= req_prev_r & ~req_sync_r;
    end
  end

  // Frame sequencer with registered QSPI pins and output strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= S_IDLE;
      cnt_r        <= 16'd0;
      p_r          <= 12'd0;
      rd_frame_r   <= 1'b0;
      last_r       <= 1'b0;
      mode_r       <= 8'h00;
      speed_r      <= 8'h00;
      trig_r       <= 8'h00;
      trig_type_r  <= 2'b00;
      nib0_r       <= 4'h0;
      rx_r         <= 8'h00;
      qd_oe_r      <= 1'b0;
      qd_out_r     <= 4'h0;
      QCK          <= 1'b0;
      QSS          <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_addr  <= 12'd0;
      sample_data  <= 8'h00;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (launch_s) begin
            mode_r      <= cfg_mode;
            speed_r     <= cfg_speed;
            trig_r      <= cfg_trigger;
            trig_type_r <= cfg_trigger_type;
            p_r         <= 12'd0;
            rd_frame_r  <= 1'b0;
            last_r      <= 1'b0;
            cnt_r       <= 16'd0;
            busy        <= 1'b1;
            QSS         <= 1'b0;
            QCK         <= 1'b0;
            // Pair 0 payload is the mode byte; take it straight from the
            // input since the latch above lands on this same edge.
            qd_oe_r     <= 1'b1;
            qd_out_r    <= cfg_mode[7:4];
            state_r     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt_r == CD_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= S_SHIFT;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        S_SHIFT: begin
          if (cnt_r == SHIFT_LAST) begin
            cnt_r   <= 16'd0;
            QCK     <= 1'b0;
            state_r <= S_HOLD;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
          // QD is sampled on the edge where QCK rises, so the value captured
          // is the one the slave set up during the preceding low phase.
          if (cnt_r == P0_RISE) begin
            QCK    <= 1'b1;
            nib0_r <= QD;
          end
          if (cnt_r == P0_FALL) begin
            QCK <= 1'b0;
            if (!rd_frame_r) begin
              qd_out_r <= wr_byte_s[3:0];
            end
          end
          if (cnt_r == P1_RISE) begin
            QCK  <= 1'b1;
            rx_r <= {nib0_r, QD};
          end
        end

        S_HOLD: begin
          if (cnt_r == CD_LAST) begin
            cnt_r   <= 16'd0;
            QSS     <= 1'b1;
            qd_oe_r <= 1'b0;
            state_r <= S_GAP;
            if (rd_frame_r) begin
              sample_valid <= 1'b1;
              sample_addr  <= p_r;
              sample_data  <= rx_r;
              last_r       <= (p_r == LAST_P);
              p_r          <= (p_r == LAST_P) ? 12'd0 : (p_r + 12'd1);
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        S_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= 16'd0;
            if (rd_frame_r && last_r) begin
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              QSS        <= 1'b0;
              rd_frame_r <= ~rd_frame_r;
              state_r    <= S_SETUP;
              // Leaving a read frame means the next frame is a write: p_r
              // already points at the new pair, so its payload is ready.
              if (rd_frame_r) begin
                qd_oe_r  <= 1'b1;
                qd_out_r <= wr_byte_s[7:4];
              end
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        S_DONE: begin
          busy       <= 1'b0;
          rd_frame_r <= 1'b0;
          last_r     <= 1'b0;
          state_r    <= S_IDLE;
        end

        default: begin
          QSS     <= 1'b1;
          QCK     <= 1'b0;
          qd_oe_r <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_scope_host.sv
// Scoreboard bench for qspi_scope_host. A behavioural slave sits on the QSPI
// pins, captures write payloads and returns bytes from a small memory.
// Expected write bytes, samples and done times are queued when a transfer is
// launched; monitors pop and compare as the DUT produces them.
module tb_qspi_scope_host;

  localparam int CD = 2;
  localparam int GP = 8;
  localparam int NS = 8;
  localparam int T  = 2 * NS * (6 * CD + GP);

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        req_n = 1'b1;
  logic [7:0]  cfg_mode = 8'h00;
  logic [7:0]  cfg_speed = 8'h00;
  logic [7:0]  cfg_trigger = 8'h00;
  logic [1:0]  cfg_trigger_type = 2'b00;
  logic        busy;
  logic        done;
  logic        sample_valid;
  logic [11:0] sample_addr;
  logic [7:0]  sample_data;
  logic        QCK;
  logic        QSS;
  wire  [3:0]  qd_bus;

  logic        slave_oe = 1'b0;
  logic [3:0]  slave_q = 4'h0;
  assign qd_bus = slave_oe ? slave_q : 4'bzzzz;

  qspi_scope_host #(.CLK_DIV(CD), .SS_GAP(GP), .NSAMPLES(NS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .auto_en(auto_en), .req_n(req_n),
    .cfg_mode(cfg_mode), .cfg_speed(cfg_speed), .cfg_trigger(cfg_trigger),
    .cfg_trigger_type(cfg_trigger_type), .busy(busy), .done(done),
    .sample_valid(sample_valid), .sample_addr(sample_addr), .sample_data(sample_data),
    .QCK(QCK), .QSS(QSS), .QD(qd_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int violations = 0;

  logic [7:0]  mem [NS];
  logic [7:0]  exp_wr_q [$];
  logic [19:0] exp_smp_q [$];
  int          exp_done_q [$];

  int          sl_frame = 0;
  int          sl_nib = 0;
  logic [7:0]  sl_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: frame start clears the nibble counter.
  always @(negedge QSS) begin
    if (resetn) begin
      sl_nib  = 0;
      sl_byte = 8'h00;
    end
  end

  // Slave: count clock pulses; capture the master's nibbles in write frames.
  always @(posedge QCK) begin
    if (resetn && !QSS) begin
      if (sl_frame % 2 == 0) sl_byte = {sl_byte[3:0], qd_bus};
      sl_nib++;
    end
  end

  // Slave: present the low nibble after the first pulse of a read frame.
  always @(negedge QCK) begin
    if (resetn && !QSS && (sl_frame % 2 == 1) && sl_nib == 1)
      slave_q = mem[(sl_frame / 2) % NS][3:0];
  end

  // Slave: frame end. After a write it takes the bus; after a read it lets go.
  always @(posedge QSS) begin
    if (resetn) begin
      chk("pulses_per_frame", sl_nib, 2);
      if (sl_frame % 2 == 0) begin
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got 0x%0h, expected none", sl_byte);
        end else begin
          chk("write_byte", sl_byte, exp_wr_q.pop_front());
        end
        slave_oe = 1'b1;
        slave_q  = mem[(sl_frame / 2) % NS][7:4];
      end else begin
        slave_oe = 1'b0;
      end
      sl_frame++;
    end
  end

  logic [19:0] smp_e;
  // Output monitor: samples, done pulses and bus ownership.
  always @(negedge clk) begin
    if (resetn) begin
      if (sample_valid) begin
        if (exp_smp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_sample: got addr %0d data 0x%0h, expected none", sample_addr, sample_data);
        end else begin
          smp_e = exp_smp_q.pop_front();
          chk("sample_addr", sample_addr, smp_e[19:8]);
          chk("sample_data", sample_data, smp_e[7:0]);
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          chk("done_cycle", cyc, exp_done_q.pop_front());
        end
      end
      if (slave_oe && dut.qd_oe_r) violations++;
      if (dut.qd_oe_r && (QSS || (sl_frame % 2 == 1))) violations++;
    end
  end

  // Reference model of one whole transfer launched on clock edge edge0.
  task automatic push_transfer(input int edge0);
    logic [7:0] b;
    for (int i = 0; i < NS; i++) begin
      case (i)
        0:       b = cfg_mode;
        1:       b = cfg_speed;
        2:       b = cfg_trigger;
        3:       b = {6'b000000, cfg_trigger_type};
        default: b = 8'h00;
      endcase
      exp_wr_q.push_back(b);
      exp_smp_q.push_back({12'(i), mem[i]});
    end
    exp_done_q.push_back(edge0 + T);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire_start();
    start = 1'b1;
    push_transfer(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (exp_done_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_done_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, budget);
      exp_done_q.delete();
    end
    tick(4);
  endtask

  task automatic rand_cfg();
    cfg_mode = 8'($urandom);
    cfg_speed = 8'($urandom);
    cfg_trigger = 8'($urandom);
    cfg_trigger_type = 2'($urandom);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NS; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by 300000 ns, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    for (int i = 0; i < NS; i++) mem[i] = 8'h40 + 8'(i);

    // Reset state
    tick(3);
    chk("rst_QSS", QSS, 1);
    chk("rst_QCK", QCK, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_addr", sample_addr, 0);
    chk("rst_data", sample_data, 0);
    resetn = 1'b1;
    tick(3);

    // Reset during SHIFT of the first write frame
    rand_cfg();
    fire_start();
    n = 0;
    while (!(QSS == 1'b0 && QCK == 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_shift", {QSS, QCK}, 2'b01);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_QSS", QSS, 1);
    chk("midrst_QCK", QCK, 0);
    chk("midrst_qd_oe", dut.qd_oe_r, 0);
    slave_oe = 1'b0;
    sl_frame = 0;
    sl_nib = 0;
    exp_wr_q.delete();
    exp_smp_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    tick(3);
    chk("postrst_busy", busy, 0);
    chk("postrst_QSS", QSS, 1);

    // Transfer A: fixed configuration, slave returns 0x40 + index
    cfg_mode = 8'h00; cfg_speed = 8'h05; cfg_trigger = 8'h80; cfg_trigger_type = 2'b01;
    fire_start();
    chk("start_busy", busy, 1);
    chk("start_QSS", QSS, 0);
    wait_done("xfer_a", T + 50);
    chk("a_busy_low", busy, 0);

    // Transfer B: random configuration and samples, one 0xA5 for nibble order
    rand_cfg();
    rand_mem();
    mem[$urandom_range(NS - 1)] = 8'hA5;
    fire_start();
    tick(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("xfer_b", T + 50);

    // Transfer C: auto mode via a 1-cycle req_n pulse; a second pulse while busy
    rand_cfg();
    rand_mem();
    auto_en = 1'b1;
    req_n = 1'b0;
    push_transfer(cyc + 4);
    @(negedge clk);
    req_n = 1'b1;
    tick(60);
    req_n = 1'b0;
    @(negedge clk);
    req_n = 1'b1;
    wait_done("xfer_c", T + 50);
    tick(10);

    // Transfer D: start and synchronised req edge in the same cycle
    rand_cfg();
    rand_mem();
    k = cyc;
    req_n = 1'b0;
    @(negedge clk);
    req_n = 1'b1;
    tick(2);
    start = 1'b1;
    push_transfer(k + 4);
    @(negedge clk);
    start = 1'b0;
    wait_done("xfer_d", T + 50);
    tick(3 * T / 2);

    chk("left_samples", exp_smp_q.size(), 0);
    chk("left_writes", exp_wr_q.size(), 0);
    chk("bus_contention", violations, 0);
    chk("end_busy", busy, 0);
    chk("end_QSS", QSS, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
